// File: rtl/if_fetch_pkg.sv
// Shared constants and payload types for the sodium instruction fetch unit.
// Optional perf counters are enabled by defining IFETCH_PERF_EN.
package if_fetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned PERF_W = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 30'h0;

  // One buffered fetch result: word PC plus the instruction returned for it
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Sequential word-address increment; wraps 3FFFFFFF -> 0
  function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of {pc, inst} between fetch and decode.
// Flush empties it in one cycle and wins over push and pop.
module if_fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  fetch_entry_t     i_wdata,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic             o_vld,
  output fetch_entry_t     o_head,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign w_push = i_push & ~i_flush & ~i_rst;
  assign w_pop  = i_pop & ~i_flush & (r_count != '0);

  // Pointer and occupancy tracking; pointers wrap naturally as DEPTH is a power of two
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset since validity comes from r_count
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_vld   = (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // The fetch credit scheme must never let a push land on a full buffer
  a_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst)
    (i_push && !i_flush) |-> (r_count < CNT_W'(DEPTH)));

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues icache word requests,
// captures returned words and buffers them for decode. Redirects flush all
// stale state. Define IFETCH_PERF_EN to add perf_req/perf_stall/perf_redir.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  output logic              icache_ack,
  output logic [ADDR_W-1:0] icache_addr,
  input  logic              icache_vld,
  input  logic [INST_W-1:0] icache_data,
  input  logic              redir_en,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              if_vld,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  input  logic              dec_rdy
`ifdef IFETCH_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_req,
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_redir
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;

  logic              w_fifo_vld;
  logic [CNT_W-1:0]  w_count;
  logic [OCC_W-1:0]  w_occ;
  logic              w_pop;
  logic              w_push;
  logic              w_ack;
  logic              w_accept;
  fetch_entry_t      w_wdata;
  fetch_entry_t      w_head;

  // Credit: buffered + in-flight entries, less this cycle's pop, must leave a free slot
  assign w_pop    = w_fifo_vld & dec_rdy;
  assign w_occ    = OCC_W'(w_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
  assign w_ack    = ~sys_rst & ~redir_en & (w_occ < OCC_W'(DEPTH));
  assign w_accept = w_ack & icache_vld;

  // Returning word is captured unless a redirect discards it this cycle
  assign w_push        = r_inflight & ~redir_en;
  assign w_wdata.pc    = r_inflight_pc;
  assign w_wdata.inst  = icache_data;

  // Fetch PC and in-flight tracking; reset beats redirect beats accept
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= RESET_PC;
    end else if (redir_en) begin
      r_pc          <= redir_pc;
      r_inflight    <= 1'b0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_pc          <= pc_incr(r_pc);
        r_inflight_pc <= r_pc;
      end
    end
  end

  if_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .i_flush (redir_en),
    .o_vld   (w_fifo_vld),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign icache_ack  = w_ack;
  assign icache_addr = r_pc;
  assign if_vld      = w_fifo_vld;
  assign if_pc       = w_head.pc;
  assign if_inst     = w_head.inst;

`ifdef IFETCH_PERF_EN
  // Wrapping event counters: accepted requests, stalled requests, redirects
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      perf_req   <= '0;
      perf_stall <= '0;
      perf_redir <= '0;
    end else begin
      if (w_accept)            perf_req   <= perf_req + PERF_W'(1);
      if (w_ack & ~icache_vld) perf_stall <= perf_stall + PERF_W'(1);
      if (redir_en)            perf_redir <= perf_redir + PERF_W'(1);
    end
  end
`endif

  // An unaccepted request must re-present the same address next cycle
  a_addr_hold : assert property (@(posedge sys_clk) disable iff (sys_rst)
    (icache_ack && !icache_vld) |=> (icache_addr == $past(icache_addr)));

  // Nothing is ever requested in a redirect cycle
  a_no_req_on_redir : assert property (@(posedge sys_clk) disable iff (sys_rst)
    redir_en |-> !icache_ack);

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch. A reference model tracks the list of
// accepted-but-not-consumed fetches and when each becomes visible to decode.
module tb_if_fetch;

  localparam logic [29:0] RST_PC = 30'h100;
  localparam int          DEPTH  = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        icache_ack;
  logic [29:0] icache_addr;
  logic        icache_vld;
  logic [31:0] icache_data;
  logic        redir_en;
  logic [29:0] redir_pc;
  logic        if_vld;
  logic [29:0] if_pc;
  logic [31:0] if_inst;
  logic        dec_rdy;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_req;
  logic [31:0] perf_stall;
  logic [31:0] perf_redir;
`endif

  if_fetch #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .icache_ack  (icache_ack),
    .icache_addr (icache_addr),
    .icache_vld  (icache_vld),
    .icache_data (icache_data),
    .redir_en    (redir_en),
    .redir_pc    (redir_pc),
    .if_vld      (if_vld),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .dec_rdy     (dec_rdy)
`ifdef IFETCH_PERF_EN
    ,
    .perf_req    (perf_req),
    .perf_stall  (perf_stall),
    .perf_redir  (perf_redir)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: outstanding fetches in program order with the cycle they become visible
  typedef struct {
    logic [29:0] pc;
    int          rdy;
  } ent_t;

  ent_t        q[$];
  logic [29:0] m_next;
  logic [29:0] m_acc_addr;
  logic        m_accept;
  logic        m_pop;
  logic        e_ack;
  logic        e_vld;
  logic [29:0] e_pc;
  logic [31:0] e_inst;
  int          cyc;
  int          n_checks;
  int          n_errors;

  function automatic logic [31:0] imem(input logic [29:0] a);
    return {a, 2'b01} ^ 32'h5a5a_c3c3;
  endfunction

  // Expected outputs for the current cycle given the inputs already driven
  task automatic predict();
    e_vld    = (q.size() > 0) && (q[0].rdy <= cyc);
    e_pc     = e_vld ? q[0].pc : 30'h0;
    e_inst   = imem(e_pc);
    m_pop    = e_vld && dec_rdy;
    e_ack    = !sys_rst && !redir_en && ((q.size() - (m_pop ? 1 : 0)) < DEPTH);
    m_accept = e_ack && icache_vld;
  endtask

  task automatic drive(input logic rst, input logic vld, input logic rdy,
                       input logic rdr, input logic [29:0] rpc);
    sys_rst    = rst;
    icache_vld = vld;
    dec_rdy    = rdy;
    redir_en   = rdr;
    redir_pc   = rpc;
    @(negedge sys_clk);
    predict();
  endtask

  // Advance one clock: update the model, then act as the icache for the next cycle
  task automatic tick();
    @(posedge sys_clk);
    if (sys_rst) begin
      q.delete();
      m_next = RST_PC;
    end else if (redir_en) begin
      q.delete();
      m_next = redir_pc;
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_accept) begin
        q.push_back('{pc: m_next, rdy: cyc + 2});
        m_acc_addr = m_next;
        m_next     = m_next + 30'd1;
      end
    end
    cyc = cyc + 1;
    #1;
    icache_data = m_accept ? imem(m_acc_addr) : $urandom;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 30'h0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 30'h0);
    n_checks++; if (icache_ack !== 1'b0) begin n_errors++; $display("FAIL reset_ack got %b exp 0", icache_ack); end
    n_checks++; if (icache_addr !== RST_PC) begin n_errors++; $display("FAIL reset_addr got %h exp %h", icache_addr, RST_PC); end
    n_checks++; if (if_vld !== 1'b0) begin n_errors++; $display("FAIL reset_if_vld got %b exp 0", if_vld); end
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 30'h0);
    n_checks++; if (icache_ack !== 1'b1 || icache_addr !== RST_PC) begin
      n_errors++; $display("FAIL reset_first_req got ack=%b addr=%h exp ack=1 addr=%h", icache_ack, icache_addr, RST_PC);
    end
    tick();
  endtask

  task automatic test_stream();
    int first_acc;
    int first_vld;
    int n_vld;
    logic [29:0] first_pc;
    first_acc = -1; first_vld = -1; n_vld = 0; first_pc = '0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 30'h0);
    tick();
    for (int k = 0; k < 14; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 30'h0);
      n_checks++; if (icache_ack !== e_ack) begin n_errors++; $display("FAIL stream_ack k=%0d got %b exp %b", k, icache_ack, e_ack); end
      n_checks++; if (icache_addr !== m_next) begin n_errors++; $display("FAIL stream_addr k=%0d got %h exp %h", k, icache_addr, m_next); end
      n_checks++; if (if_vld !== e_vld) begin n_errors++; $display("FAIL stream_vld k=%0d got %b exp %b", k, if_vld, e_vld); end
      if (e_vld) begin
        n_checks++; if (if_pc !== e_pc || if_inst !== e_inst) begin
          n_errors++; $display("FAIL stream_head k=%0d got %h/%h exp %h/%h", k, if_pc, if_inst, e_pc, e_inst);
        end
      end
      if (icache_ack === 1'b1 && first_acc < 0) first_acc = k;
      if (if_vld === 1'b1) begin
        n_vld++;
        if (first_vld < 0) begin first_vld = k; first_pc = if_pc; end
      end
      tick();
    end
    n_checks++; if (first_vld - first_acc !== 2 || first_pc !== RST_PC) begin
      n_errors++; $display("FAIL stream_latency got %0d pc %h exp 2 pc %h", first_vld - first_acc, first_pc, RST_PC);
    end
    n_checks++; if (n_vld !== 12) begin n_errors++; $display("FAIL stream_throughput got %0d exp 12", n_vld); end
  endtask

  task automatic test_stall();
    logic vld;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 30'h20);
    n_checks++; if (icache_ack !== 1'b0) begin n_errors++; $display("FAIL stall_redir_ack got %b exp 0", icache_ack); end
    tick();
    for (int k = 1; k <= 12; k++) begin
      vld = !(k >= 1 && k <= 3);
      drive(1'b0, vld, 1'b1, 1'b0, 30'h0);
      if (k <= 3) begin
        n_checks++; if (icache_addr !== 30'h20 || icache_ack !== 1'b1) begin
          n_errors++; $display("FAIL stall_hold k=%0d got ack=%b addr=%h exp ack=1 addr=20", k, icache_ack, icache_addr);
        end
      end
      n_checks++; if (icache_ack !== e_ack || icache_addr !== m_next) begin
        n_errors++; $display("FAIL stall_req k=%0d got %b/%h exp %b/%h", k, icache_ack, icache_addr, e_ack, m_next);
      end
      n_checks++; if (if_vld !== e_vld) begin n_errors++; $display("FAIL stall_vld k=%0d got %b exp %b", k, if_vld, e_vld); end
      if (e_vld) begin
        n_checks++; if (if_pc !== e_pc || if_inst !== e_inst) begin
          n_errors++; $display("FAIL stall_head k=%0d got %h/%h exp %h/%h", k, if_pc, if_inst, e_pc, e_inst);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int n_acc;
    n_acc = 0;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 30'h200);
    tick();
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 30'h0);
      n_checks++; if (icache_ack !== e_ack || icache_addr !== m_next) begin
        n_errors++; $display("FAIL bp_req k=%0d got %b/%h exp %b/%h", k, icache_ack, icache_addr, e_ack, m_next);
      end
      if (icache_ack === 1'b1 && icache_vld) n_acc++;
      if (k == 6) begin
        n_checks++; if (icache_ack !== 1'b0 || if_vld !== 1'b1) begin
          n_errors++; $display("FAIL bp_full got ack=%b vld=%b exp ack=0 vld=1", icache_ack, if_vld);
        end
      end
      tick();
    end
    n_checks++; if (n_acc !== DEPTH) begin n_errors++; $display("FAIL bp_captured got %0d exp %0d", n_acc, DEPTH); end
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 30'h0);
      if (k == 1) begin
        n_checks++; if (if_pc !== 30'h200) begin n_errors++; $display("FAIL bp_resume_pc got %h exp 200", if_pc); end
      end
      n_checks++; if (icache_ack !== e_ack || if_vld !== e_vld) begin
        n_errors++; $display("FAIL bp_drain k=%0d got ack=%b vld=%b exp ack=%b vld=%b", k, icache_ack, if_vld, e_ack, e_vld);
      end
      if (e_vld) begin
        n_checks++; if (if_pc !== e_pc || if_inst !== e_inst) begin
          n_errors++; $display("FAIL bp_head k=%0d got %h/%h exp %h/%h", k, if_pc, if_inst, e_pc, e_inst);
        end
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 30'h300);
    tick();
    for (int k = 1; k <= 2; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 30'h0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 30'h400);
    n_checks++; if (icache_ack !== 1'b0 || if_vld !== 1'b1) begin
      n_errors++; $display("FAIL redir_setup got ack=%b vld=%b exp ack=0 vld=1", icache_ack, if_vld);
    end
    tick();
    for (int k = 1; k <= 7; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 30'h0);
      if (k < 3) begin
        n_checks++; if (if_vld !== 1'b0) begin n_errors++; $display("FAIL redir_flush k=%0d got vld=%b exp 0", k, if_vld); end
      end
      if (k == 3) begin
        n_checks++; if (if_vld !== 1'b1 || if_pc !== 30'h400) begin
          n_errors++; $display("FAIL redir_first got vld=%b pc=%h exp vld=1 pc=400", if_vld, if_pc);
        end
      end
      n_checks++; if (icache_ack !== e_ack || icache_addr !== m_next || if_vld !== e_vld) begin
        n_errors++; $display("FAIL redir_model k=%0d got %b/%h/%b exp %b/%h/%b", k, icache_ack, icache_addr, if_vld, e_ack, m_next, e_vld);
      end
      if (e_vld) begin
        n_checks++; if (if_pc !== e_pc || if_inst !== e_inst) begin
          n_errors++; $display("FAIL redir_head k=%0d got %h/%h exp %h/%h", k, if_pc, if_inst, e_pc, e_inst);
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 30'h3FFF_FFFE);
    tick();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 30'h0);
      if (k == 3) begin
        n_checks++; if (icache_addr !== 30'h0) begin n_errors++; $display("FAIL wrap_addr got %h exp 0", icache_addr); end
      end
      if (k == 4) begin
        n_checks++; if (if_vld !== 1'b1 || if_pc !== 30'h3FFF_FFFF) begin
          n_errors++; $display("FAIL wrap_pc_top got %b/%h exp 1/3fffffff", if_vld, if_pc);
        end
      end
      if (k == 5) begin
        n_checks++; if (if_vld !== 1'b1 || if_pc !== 30'h0) begin
          n_errors++; $display("FAIL wrap_pc_zero got %b/%h exp 1/0", if_vld, if_pc);
        end
      end
      n_checks++; if (icache_addr !== m_next || if_vld !== e_vld) begin
        n_errors++; $display("FAIL wrap_model k=%0d got %h/%b exp %h/%b", k, icache_addr, if_vld, m_next, e_vld);
      end
      if (e_vld) begin
        n_checks++; if (if_inst !== e_inst) begin n_errors++; $display("FAIL wrap_inst k=%0d got %h exp %h", k, if_inst, e_inst); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic        rst;
    logic        rdr;
    logic [29:0] rpc;
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 63) == 0);
      rdr = !rst && ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (30'h3FFF_FFFC | 30'($urandom_range(0, 3))) : 30'($urandom);
      drive(rst, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, rdr, rpc);
      n_checks++; if (icache_ack !== e_ack) begin n_errors++; $display("FAIL rand_ack k=%0d got %b exp %b", k, icache_ack, e_ack); end
      if (!rst) begin
        n_checks++; if (icache_addr !== m_next) begin n_errors++; $display("FAIL rand_addr k=%0d got %h exp %h", k, icache_addr, m_next); end
      end
      if (!rdr) begin
        n_checks++; if (if_vld !== e_vld) begin n_errors++; $display("FAIL rand_vld k=%0d got %b exp %b", k, if_vld, e_vld); end
        if (e_vld) begin
          n_checks++; if (if_pc !== e_pc || if_inst !== e_inst) begin
            n_errors++; $display("FAIL rand_head k=%0d got %h/%h exp %h/%h", k, if_pc, if_inst, e_pc, e_inst);
          end
        end
      end
      tick();
    end
  endtask

`ifdef IFETCH_PERF_EN
  task automatic test_perf();
    logic vld_pat [15];
    vld_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    drive(1'b1, 1'b0, 1'b1, 1'b0, 30'h0);
    tick();
    for (int k = 0; k < 15; k++) begin
      drive(1'b0, vld_pat[k], 1'b1, (k == 7), 30'h500);
      if (k == 0) begin
        n_checks++; if (perf_req !== 32'd0 || perf_stall !== 32'd0 || perf_redir !== 32'd0) begin
          n_errors++; $display("FAIL perf_init got %0d/%0d/%0d exp 0/0/0", perf_req, perf_stall, perf_redir);
        end
      end
      n_checks++; if (icache_ack !== e_ack) begin n_errors++; $display("FAIL perf_ack k=%0d got %b exp %b", k, icache_ack, e_ack); end
      tick();
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 30'h0);
    n_checks++; if (perf_req !== 32'd10) begin n_errors++; $display("FAIL perf_req got %0d exp 10", perf_req); end
    n_checks++; if (perf_stall !== 32'd4) begin n_errors++; $display("FAIL perf_stall got %0d exp 4", perf_stall); end
    n_checks++; if (perf_redir !== 32'd1) begin n_errors++; $display("FAIL perf_redir got %0d exp 1", perf_redir); end
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 30'h0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 30'h0);
    n_checks++; if (perf_req !== 32'd0 || perf_stall !== 32'd0 || perf_redir !== 32'd0) begin
      n_errors++; $display("FAIL perf_clear got %0d/%0d/%0d exp 0/0/0", perf_req, perf_stall, perf_redir);
    end
    tick();
  endtask
`endif

  initial begin
    sys_rst     = 1'b1;
    icache_vld  = 1'b0;
    dec_rdy     = 1'b0;
    redir_en    = 1'b0;
    redir_pc    = '0;
    icache_data = $urandom;
    m_next      = RST_PC;
    m_acc_addr  = RST_PC;
    cyc         = 0;
    n_checks    = 0;
    n_errors    = 0;
    test_reset();
    test_stream();
    test_stall();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_random();
`ifdef IFETCH_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
